rd_writeback: RTL and testbench
===============================

RD_WRITEBACK -- requirements
Module: rd_writeback

Interface
REQ-001 SHALL have parameter N, default 16, data width of result and register-file write data.
REQ-002 SHALL have parameter WB_MAX_OP, default 4'b0100, highest op_code that writes back; op_code 0000..WB_MAX_OP writes, all others do not.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 op_code  input  4  opcode of the incoming ALU result.
REQ-006 res_in  input  N  ALU result.
REQ-007 rd_in  input  4  destination register index.
REQ-008 in_valid  input  1  ALU result present this cycle.
REQ-009 in_ready  output  1  block can accept this cycle.
REQ-010 wr_en  output  1  register-file write request.
REQ-011 wr_addr  output  4  register-file write index.
REQ-012 wr_data  output  N  register-file write data.
REQ-013 wr_ack  input  1  register file accepted the write this cycle.
REQ-014 fwd_valid  output  1  a pending write exists for bypass.
REQ-015 fwd_addr  output  4  rd of youngest pending write.
REQ-016 fwd_data  output  N  data of youngest pending write.

Function
REQ-017 SHALL hold pending writes in a 2-entry in-order queue; states EMPTY (0), ONE (1), FULL (2).
REQ-018 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL; derived from registered state only, no combinational path from in_valid or wr_ack.
REQ-019 Accept SHALL occur when in_valid && in_ready at a rising edge.
REQ-020 An accepted op_code <= WB_MAX_OP SHALL enqueue {rd_in, res_in}; an accepted op_code > WB_MAX_OP SHALL be consumed with no enqueue and no state change.
REQ-021 wr_en SHALL be 1 when state != EMPTY; wr_addr/wr_data SHALL show the head entry and stay stable until dequeued.
REQ-022 Dequeue SHALL occur when wr_en && wr_ack at a rising edge; wr_ack while wr_en=0 SHALL be ignored.
REQ-023 Latency: entry accepted into EMPTY at edge k SHALL present wr_en=1 in cycle k+1; minimum one cycle from accept to write.
REQ-024 Simultaneous enqueue and dequeue in ONE SHALL remain in ONE with the new entry as head; in EMPTY the dequeue cannot occur.
REQ-025 Transitions: EMPTY->ONE on enqueue; ONE->FULL on enqueue without dequeue; ONE->EMPTY on dequeue without enqueue; FULL->ONE on dequeue (no enqueue possible).
REQ-026 fwd_valid SHALL equal wr_en; fwd_addr/fwd_data SHALL be the youngest entry (tail in FULL, head in ONE).
REQ-027 Two pending entries with same rd SHALL both be written, oldest first; no merging.
REQ-028 When wr_en=0, wr_addr, wr_data, fwd_addr, fwd_data SHALL be 0.

Reset
REQ-029 rst_n low SHALL immediately force state EMPTY, wr_en=0, fwd_valid=0, in_ready=1, all address/data outputs 0.
REQ-030 Reset asserted mid-operation SHALL discard all pending entries; no write is issued after reset release until a new accept.
REQ-031 Queue storage contents need no reset beyond output masking per REQ-028.

Structure
REQ-032 Opcode constants (0000..0100 writing opcodes, WB_MAX_OP) and the state enum SHALL live in the shared CPU package.
REQ-033 Queue storage SHALL be one sub-module wb_queue2 (2-entry FIFO with count); rd_writeback holds opcode filtering and forwarding.

Verification
REQ-034 Reset, then op=0001, rd=3, res=16'h00AA, in_valid one cycle, wr_ack=1 -> next cycle wr_en=1, wr_addr=3, wr_data=00AA, fwd_valid=1; one cycle later wr_en=0.
REQ-035 op=0111 rd=5 accepted -> in_ready stays 1, wr_en never asserts, state EMPTY.
REQ-036 wr_ack=0, two accepts (rd=1 data 1111, rd=2 data 2222) -> in_ready=0, wr_addr=1, fwd_addr=2/fwd_data=2222; third in_valid not accepted; wr_ack=1 two cycles -> writes 1 then 2, in_ready returns 1.
REQ-037 State ONE, same-edge enqueue (rd=4 data 4444) and wr_ack -> old head written, next cycle wr_addr=4, state ONE.
REQ-038 State FULL, rst_n pulsed low mid-cycle -> wr_en=0, in_ready=1 immediately, no write after release.

Source files
------------

// File: rtl/rd_writeback_pkg.sv
// Shared CPU definitions for the writeback stage.
//   - writing opcode constants and default highest writing opcode
//   - pending-write queue state encoding
//   - helper deciding whether an opcode produces a register write
package rd_writeback_pkg;

  localparam logic [3:0] OP_0000       = 4'b0000;
  localparam logic [3:0] OP_0001       = 4'b0001;
  localparam logic [3:0] OP_0010       = 4'b0010;
  localparam logic [3:0] OP_0011       = 4'b0011;
  localparam logic [3:0] OP_0100       = 4'b0100;
  localparam logic [3:0] WB_MAX_OP_DEF = OP_0100;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } wbq_state_e;

  // Opcodes 0..max write back; everything above is consumed silently.
  function automatic logic op_writes(input logic [3:0] op, input logic [3:0] max_op);
    return (op <= max_op);
  endfunction

endpackage

// File: rtl/rd_writeback_if.sv
// ALU-result / register-file / bypass bundle of the writeback stage.
//   slave  : the writeback block (consumes ALU results, drives writes/bypass)
//   master : the surrounding pipeline / register file
interface rd_writeback_if #(parameter int N = 16);
  logic [3:0]   op_code;
  logic [N-1:0] res_in;
  logic [3:0]   rd_in;
  logic         in_valid;
  logic         in_ready;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [N-1:0] wr_data;
  logic         wr_ack;
  logic         fwd_valid;
  logic [3:0]   fwd_addr;
  logic [N-1:0] fwd_data;

  modport slave (
    input  op_code, res_in, rd_in, in_valid, wr_ack,
    output in_ready, wr_en, wr_addr, wr_data, fwd_valid, fwd_addr, fwd_data
  );

  modport master (
    output op_code, res_in, rd_in, in_valid, wr_ack,
    input  in_ready, wr_en, wr_addr, wr_data, fwd_valid, fwd_addr, fwd_data
  );
endinterface

// File: rtl/rd_writeback_wb_queue2.sv
// wb_queue2: 2-entry in-order FIFO with occupancy state.
//   clk, rst_n   : clock, async active-low reset (clears occupancy only)
//   enq_i/enq_data_i : push request and payload (ignored when FULL)
//   deq_i        : pop request (ignored when EMPTY)
//   full_o       : registered full flag
//   count_o      : occupancy 0..2
//   head_o       : oldest entry, 0 when empty
//   youngest_o   : newest entry, 0 when empty
module wb_queue2
  import rd_writeback_pkg::*;
#(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enq_i,
  input  logic [W-1:0] enq_data_i,
  input  logic         deq_i,
  output logic         full_o,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o,
  output logic [W-1:0] youngest_o
);

  wbq_state_e   state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         enq, deq;

  assign enq = enq_i && (state_q != FULL);
  assign deq = deq_i && (state_q != EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Storage is never reset; outputs are masked by state instead.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: if (enq) begin
        state_d = ONE;
        head_d  = enq_data_i;
      end
      ONE: begin
        if (enq && deq) begin
          head_d = enq_data_i;   // old head leaves, new entry becomes head
        end else if (enq) begin
          state_d = FULL;
          tail_d  = enq_data_i;
        end else if (deq) begin
          state_d = EMPTY;
        end
      end
      FULL: if (deq) begin
        state_d = ONE;
        head_d  = tail_q;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    full_o     = 1'b0;
    count_o    = 2'd0;
    head_o     = '0;
    youngest_o = '0;
    case (state_q)
      ONE: begin
        count_o    = 2'd1;
        head_o     = head_q;
        youngest_o = head_q;
      end
      FULL: begin
        full_o     = 1'b1;
        count_o    = 2'd2;
        head_o     = head_q;
        youngest_o = tail_q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rd_writeback.sv
// rd_writeback: ALU result writeback with 2-deep pending-write queue.
//   clk, rst_n : clock, async active-low reset
//   bus        : rd_writeback_if.slave
//     op_code/res_in/rd_in/in_valid/in_ready : ALU result handshake
//     wr_en/wr_addr/wr_data/wr_ack           : register-file write port
//     fwd_valid/fwd_addr/fwd_data            : bypass of youngest pending write
module rd_writeback
  import rd_writeback_pkg::*;
#(
  parameter int         N         = 16,
  parameter logic [3:0] WB_MAX_OP = WB_MAX_OP_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  rd_writeback_if.slave  bus
);

  localparam int W = N + 4;

  logic         full, accept, enq;
  logic [1:0]   count;
  logic [W-1:0] head, youngest;

  // in_ready comes only from registered occupancy.
  assign bus.in_ready = !full;
  assign accept       = bus.in_valid && !full;
  // Non-writing opcodes are accepted and dropped here.
  assign enq          = accept && op_writes(bus.op_code, WB_MAX_OP);

  wb_queue2 #(.W(W)) u_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .enq_i      (enq),
    .enq_data_i ({bus.rd_in, bus.res_in}),
    .deq_i      (bus.wr_ack),
    .full_o     (full),
    .count_o    (count),
    .head_o     (head),
    .youngest_o (youngest)
  );

  assign bus.wr_en     = (count != 2'd0);
  assign bus.wr_addr   = head[W-1:N];
  assign bus.wr_data   = head[N-1:0];
  assign bus.fwd_valid = bus.wr_en;
  assign bus.fwd_addr  = youngest[W-1:N];
  assign bus.fwd_data  = youngest[N-1:0];

endmodule

// File: tb/tb_rd_writeback.sv
module tb_rd_writeback;

  logic clk;
  logic rst_n;
  int   n_pass = 0;
  int   n_tot  = 0;

  rd_writeback_if #(.N(16)) bus ();

  rd_writeback #(.N(16), .WB_MAX_OP(4'b0100)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] res;
    logic        ack;
    logic        e_en;
    logic [3:0]  e_addr;
    logic [15:0] e_data;
    logic        e_rdy;
    logic [3:0]  e_faddr;
    logic [15:0] e_fdata;
  } vec_t;

  vec_t tbl[12];
  logic [19:0] mq[$];

  function automatic vec_t mk(logic v, logic [3:0] op, logic [3:0] rd, logic [15:0] res,
                              logic ack, logic e_en, logic [3:0] e_addr, logic [15:0] e_data,
                              logic e_rdy, logic [3:0] e_faddr, logic [15:0] e_fdata);
    vec_t t;
    t.v = v; t.op = op; t.rd = rd; t.res = res; t.ack = ack;
    t.e_en = e_en; t.e_addr = e_addr; t.e_data = e_data; t.e_rdy = e_rdy;
    t.e_faddr = e_faddr; t.e_fdata = e_fdata;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rd,
                       input logic [15:0] res, input logic ack);
    bus.in_valid = v;
    bus.op_code  = op;
    bus.rd_in    = rd;
    bus.res_in   = res;
    bus.wr_ack   = ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".wr_en"},     32'(bus.wr_en),     32'd0);
    chk({nm, ".in_ready"},  32'(bus.in_ready),  32'd1);
    chk({nm, ".fwd_valid"}, 32'(bus.fwd_valid), 32'd0);
    chk({nm, ".wr_addr"},   32'(bus.wr_addr),   32'd0);
    chk({nm, ".wr_data"},   32'(bus.wr_data),   32'd0);
    chk({nm, ".fwd_addr"},  32'(bus.fwd_addr),  32'd0);
    chk({nm, ".fwd_data"},  32'(bus.fwd_data),  32'd0);
  endtask

  initial begin
    // Expected values are the outputs after the edge that applies the vector.
    tbl[0]  = mk(1, 4'h1, 4'h3, 16'h00AA, 1, 1, 4'h3, 16'h00AA, 1, 4'h3, 16'h00AA);
    tbl[1]  = mk(0, 4'h0, 4'h0, 16'h0000, 1, 0, 4'h0, 16'h0000, 1, 4'h0, 16'h0000);
    tbl[2]  = mk(1, 4'h7, 4'h5, 16'h5555, 0, 0, 4'h0, 16'h0000, 1, 4'h0, 16'h0000);
    tbl[3]  = mk(1, 4'h1, 4'h1, 16'h1111, 0, 1, 4'h1, 16'h1111, 1, 4'h1, 16'h1111);
    tbl[4]  = mk(1, 4'h2, 4'h2, 16'h2222, 0, 1, 4'h1, 16'h1111, 0, 4'h2, 16'h2222);
    tbl[5]  = mk(1, 4'h3, 4'h9, 16'h9999, 0, 1, 4'h1, 16'h1111, 0, 4'h2, 16'h2222);
    tbl[6]  = mk(0, 4'h0, 4'h0, 16'h0000, 1, 1, 4'h2, 16'h2222, 1, 4'h2, 16'h2222);
    tbl[7]  = mk(1, 4'h4, 4'h4, 16'h4444, 1, 1, 4'h4, 16'h4444, 1, 4'h4, 16'h4444);
    tbl[8]  = mk(1, 4'h0, 4'h4, 16'h0404, 0, 1, 4'h4, 16'h4444, 0, 4'h4, 16'h0404);
    tbl[9]  = mk(0, 4'h0, 4'h0, 16'h0000, 1, 1, 4'h4, 16'h0404, 1, 4'h4, 16'h0404);
    tbl[10] = mk(0, 4'h0, 4'h0, 16'h0000, 1, 0, 4'h0, 16'h0000, 1, 4'h0, 16'h0000);
    tbl[11] = mk(1, 4'h5, 4'h6, 16'h6666, 0, 0, 4'h0, 16'h0000, 1, 4'h0, 16'h0000);

    drive(0, 4'h0, 4'h0, 16'h0, 0);
    rst_n = 1'b0;
    #1;
    chk_idle("reset");
    step(); step();
    rst_n = 1'b1;
    step();
    chk_idle("post_reset");

    // Directed table
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].rd, tbl[i].res, tbl[i].ack);
      step();
      chk($sformatf("v%0d.wr_en", i),     32'(bus.wr_en),     32'(tbl[i].e_en));
      chk($sformatf("v%0d.wr_addr", i),   32'(bus.wr_addr),   32'(tbl[i].e_addr));
      chk($sformatf("v%0d.wr_data", i),   32'(bus.wr_data),   32'(tbl[i].e_data));
      chk($sformatf("v%0d.in_ready", i),  32'(bus.in_ready),  32'(tbl[i].e_rdy));
      chk($sformatf("v%0d.fwd_valid", i), 32'(bus.fwd_valid), 32'(tbl[i].e_en));
      chk($sformatf("v%0d.fwd_addr", i),  32'(bus.fwd_addr),  32'(tbl[i].e_faddr));
      chk($sformatf("v%0d.fwd_data", i),  32'(bus.fwd_data),  32'(tbl[i].e_fdata));
    end

    // Fill to FULL, then reset mid-cycle
    drive(1, 4'h1, 4'h7, 16'h7777, 0); step();
    drive(1, 4'h2, 4'h8, 16'h8888, 0); step();
    chk("full.in_ready", 32'(bus.in_ready), 32'd0);
    drive(0, 4'h0, 4'h0, 16'h0, 1);
    #3 rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("after_rst%0d.wr_en", i), 32'(bus.wr_en), 32'd0);
      chk($sformatf("after_rst%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
    end

    // Random stimulus against a queue model
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      logic        v, ack, e_en;
      logic [3:0]  op, rd, e_addr, e_faddr;
      logic [15:0] res, e_data, e_fdata;
      int          sz;
      v   = ($urandom_range(0, 3) != 0);
      op  = 4'($urandom_range(0, 15));
      rd  = 4'($urandom_range(0, 15));
      res = 16'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      sz  = mq.size();
      drive(v, op, rd, res, ack);
      if (ack && sz > 0) void'(mq.pop_front());
      if (v && sz < 2 && op <= 4'h4) mq.push_back({rd, res});
      step();
      e_en    = (mq.size() > 0);
      e_addr  = e_en ? mq[0][19:16] : 4'h0;
      e_data  = e_en ? mq[0][15:0]  : 16'h0;
      e_faddr = e_en ? mq[mq.size()-1][19:16] : 4'h0;
      e_fdata = e_en ? mq[mq.size()-1][15:0]  : 16'h0;
      chk($sformatf("r%0d.wr_en", c),     32'(bus.wr_en),     32'(e_en));
      chk($sformatf("r%0d.wr_addr", c),   32'(bus.wr_addr),   32'(e_addr));
      chk($sformatf("r%0d.wr_data", c),   32'(bus.wr_data),   32'(e_data));
      chk($sformatf("r%0d.in_ready", c),  32'(bus.in_ready),  32'(mq.size() < 2));
      chk($sformatf("r%0d.fwd_valid", c), 32'(bus.fwd_valid), 32'(e_en));
      chk($sformatf("r%0d.fwd_addr", c),  32'(bus.fwd_addr),  32'(e_faddr));
      chk($sformatf("r%0d.fwd_data", c),  32'(bus.fwd_data),  32'(e_fdata));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
